// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control-token constants, token-to-{C1,C0} mapping and alignment FSM states
package tmds_pkg;
   localparam logic [9:0] TOK_C00 = 10'h354;
   localparam logic [9:0] TOK_C01 = 10'h0AB;
   localparam logic [9:0] TOK_C10 = 10'h154;
   localparam logic [9:0] TOK_C11 = 10'h2AB;
   typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;
   // returns {is_ctrl, C1, C0}; non-token symbols give 3'b000
   function automatic logic [2:0] tok_map(input logic [9:0] s);
      return s == TOK_C00 ? 3'b100 :
             s == TOK_C01 ? 3'b101 :
             s == TOK_C10 ? 3'b110 :
             s == TOK_C11 ? 3'b111 : 3'b000;
   endfunction
endpackage

// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if: symbol input and decoded/status outputs of one TMDS channel
//   sym_i      10  received symbol, bit 0 first on the wire
//   data_o      8  decoded pixel byte
//   de_o        1  data period flag
//   ctrl_o      2  {C1,C0}
//   locked_o    1  word alignment achieved
//   bitslip_o   1  one-cycle bitslip request to the deserializer
//   err_cnt_o  16  lock-loss count
interface tmds_channel_decoder_if;
   logic [9:0]  sym_i;
   logic [7:0]  data_o;
   logic        de_o;
   logic [1:0]  ctrl_o;
   logic        locked_o;
   logic        bitslip_o;
   logic [15:0] err_cnt_o;
   modport master (output sym_i, input data_o, de_o, ctrl_o, locked_o, bitslip_o, err_cnt_o);
   modport slave  (input sym_i, output data_o, de_o, ctrl_o, locked_o, bitslip_o, err_cnt_o);
endinterface

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational TMDS symbol classification and 8-bit data decode
//   sym      in  10  symbol
//   is_ctrl  out  1  symbol is one of the four control tokens
//   ctrl     out  2  {C1,C0} of the token
//   data     out  8  decoded byte (meaningful when is_ctrl=0)
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] sym,
   output logic       is_ctrl,
   output logic [1:0] ctrl,
   output logic [7:0] data
);
   logic [7:0] q;
   assign q = sym[9] ? ~sym[7:0] : sym[7:0];
   assign {is_ctrl, ctrl} = tok_map(sym);
   // sym[8]=0 marks XNOR encoding, so invert the neighbour XOR
   assign data = {q[7:1] ^ q[6:0] ^ {7{~sym[8]}}, q[0]};
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS channel decoder with control-token bit-slip word alignment
//   clk_i   pixel clock
//   rstn_i  asynchronous active-low reset
//   bus     tmds_channel_decoder_if.slave (sym_i in; data_o, de_o, ctrl_o, locked_o, bitslip_o, err_cnt_o out)
//   Macro TMDS_DEC_ERRCNT_EN builds the saturating lock-loss counter; otherwise err_cnt_o is 0.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN  = 16,
   parameter int WINDOW    = 1024,
   parameter int SLIP_WAIT = 8
) (
   input logic clk_i,
   input logic rstn_i,
   tmds_channel_decoder_if.slave bus
);
   localparam int RW = $clog2(CTRL_RUN + 1);
   localparam int WW = $clog2(WINDOW);
   localparam int SW = $clog2(SLIP_WAIT + 1);
   logic [9:0]    sym_r;
   logic          v1;
   logic          is_ctrl;
   logic [1:0]    ctrl;
   logic [7:0]    data;
   logic [RW-1:0] run;
   logic [WW-1:0] win;
   logic [SW-1:0] slip;
   logic          tok, run_done, win_exp;
   state_t        state, state_nx;
   tmds_symbol_decode u_dec (.sym(sym_r), .is_ctrl(is_ctrl), .ctrl(ctrl), .data(data));
   // v1 keeps the pre-reset contents of sym_r from being decoded or counted
   assign tok      = v1 && is_ctrl;
   assign run_done = tok && run == RW'(CTRL_RUN - 1) && state != SLIP;
   assign win_exp  = win == WW'(WINDOW - 1);
   assign bus.locked_o = state == LOCKED;
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) state <= SEARCH;
      else state <= state_nx;
   // run completion takes priority over window expiry in both SEARCH and LOCKED
   always_comb begin
      state_nx = state;
      state_nx = state == SEARCH ? (run_done ? LOCKED : win_exp ? SLIP : SEARCH) :
                 state == SLIP   ? (slip == SW'(SLIP_WAIT - 1) ? SEARCH : SLIP) :
                 (win_exp && !run_done ? SEARCH : LOCKED);
   end
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         sym_r         <= '0;
         v1            <= 1'b0;
         run           <= '0;
         win           <= '0;
         slip          <= '0;
         bus.bitslip_o <= 1'b0;
         bus.data_o    <= '0;
         bus.de_o      <= 1'b0;
         bus.ctrl_o    <= '0;
      end else begin
         sym_r         <= bus.sym_i;
         v1            <= 1'b1;
         run           <= state == SLIP || !tok ? '0 : run == RW'(CTRL_RUN) ? run : run + 1'b1;
         win           <= (state != SEARCH && state_nx == SEARCH) || run_done || win_exp ? '0 : win + 1'b1;
         slip          <= state == SLIP ? slip + 1'b1 : '0;
         bus.bitslip_o <= state == SEARCH && state_nx == SLIP;
         if (v1) begin
            bus.de_o <= !is_ctrl;
            if (is_ctrl) bus.ctrl_o <= ctrl;
            else bus.data_o <= data;
         end
      end
`ifdef TMDS_DEC_ERRCNT_EN
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) bus.err_cnt_o <= '0;
      else if (state == LOCKED && state_nx == SEARCH && bus.err_cnt_o != 16'hFFFF)
         bus.err_cnt_o <= bus.err_cnt_o + 1'b1;
`else
   assign bus.err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed self-checking bench for tmds_channel_decoder
module tb_tmds_channel_decoder;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   slips = 0;
   int   pt [4];
   int   off = 0;
   bit   rot_en = 1'b0;
   tmds_channel_decoder_if bus ();
   tmds_channel_decoder dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [9:0] rot(input logic [9:0] v, input int n);
      logic [19:0] t;
      t = {v, v};
      return t[n +: 10];
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.bitslip_o) begin
         if (slips < 4) pt[slips] = cyc;
         slips++;
         if (rot_en) off--;
      end
      if (rot_en) bus.sym_i = rot(10'h354, (off + 10) % 10);
   endtask
   task automatic rst_dut();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc = 0;
      slips = 0;
   endtask
   logic [9:0] vs [4] = '{10'h0FF, 10'h1F0, 10'h2F0, 10'h201};
   logic [7:0] vd [4] = '{8'hFF, 8'h10, 8'hEF, 8'hFC};
   initial begin
      // reset state and first lock on a steady C=00 token stream
      bus.sym_i = 10'h354;
      rst_dut();
      chk("rst_data", bus.data_o, 0);
      chk("rst_de", bus.de_o, 0);
      chk("rst_ctrl", bus.ctrl_o, 0);
      chk("rst_lock", bus.locked_o, 0);
      chk("rst_slip", bus.bitslip_o, 0);
      chk("rst_err", bus.err_cnt_o, 0);
      repeat (16) step();
      chk("lock_early", bus.locked_o, 0);
      step();
      chk("lock_16", bus.locked_o, 1);
      chk("lock_ctrl", bus.ctrl_o, 2'b00);
      chk("lock_de", bus.de_o, 0);
      chk("lock_noslip", slips, 0);
      // data then control token through the 2-stage pipe
      bus.sym_i = 10'h100;
      step();
      bus.sym_i = 10'h0AB;
      step();
      chk("d100_de", bus.de_o, 1);
      chk("d100_data", bus.data_o, 8'h00);
      step();
      chk("c01_de", bus.de_o, 0);
      chk("c01_ctrl", bus.ctrl_o, 2'b01);
      for (int i = 0; i < 4; i++) begin
         bus.sym_i = vs[i];
         step();
         step();
         chk($sformatf("dec_%0h", vs[i]), bus.data_o, vd[i]);
         chk("dec_ctrl_hold", bus.ctrl_o, 2'b01);
      end
      bus.sym_i = 10'h154;
      step();
      step();
      chk("c10_ctrl", bus.ctrl_o, 2'b10);
      chk("c10_data_hold", bus.data_o, 8'hFC);
      bus.sym_i = 10'h2AB;
      step();
      step();
      chk("c11_ctrl", bus.ctrl_o, 2'b11);
      chk("still_locked", bus.locked_o, 1);
      // lock loss: a fresh run completes, then WINDOW cycles of data only
      bus.sym_i = 10'h100;
      repeat (2) step();
      bus.sym_i = 10'h354;
      repeat (16) step();
      bus.sym_i = 10'h100;
      step();
      repeat (1023) step();
      chk("loss_early", bus.locked_o, 1);
      step();
      chk("loss", bus.locked_o, 0);
`ifdef TMDS_DEC_ERRCNT_EN
      chk("loss_err", bus.err_cnt_o, 1);
`else
      chk("loss_err", bus.err_cnt_o, 0);
`endif
      // token stream rotated by 3 bits, deserializer model slips back one bit per pulse
      off = 3;
      rot_en = 1'b1;
      bus.sym_i = rot(10'h354, 3);
      rst_dut();
      for (int i = 0; i < 5000 && !bus.locked_o; i++) step();
      rot_en = 1'b0;
      chk("rot_locked", bus.locked_o, 1);
      chk("rot_pulses", slips, 3);
      chk("rot_first", pt[0], 1024);
      chk("rot_gap1", pt[1] - pt[0], 1032);
      chk("rot_gap2", pt[2] - pt[1], 1032);
      // run completion in the very cycle the SEARCH window expires
      bus.sym_i = 10'h100;
      rst_dut();
      repeat (1007) step();
      bus.sym_i = 10'h354;
      repeat (16) step();
      chk("tie_early", bus.locked_o, 0);
      step();
      chk("tie_lock", bus.locked_o, 1);
      chk("tie_noslip", slips, 0);
      // asynchronous reset while locked mid-line
      bus.sym_i = 10'h2AB;
      repeat (2) step();
      bus.sym_i = 10'h0FF;
      repeat (2) step();
      chk("pre_rst_data", bus.data_o, 8'hFF);
      chk("pre_rst_ctrl", bus.ctrl_o, 2'b11);
      rstn = 1'b0;
      #1;
      chk("arst_data", bus.data_o, 0);
      chk("arst_de", bus.de_o, 0);
      chk("arst_ctrl", bus.ctrl_o, 0);
      chk("arst_lock", bus.locked_o, 0);
      chk("arst_slip", bus.bitslip_o, 0);
      bus.sym_i = 10'h354;
      rst_dut();
      repeat (16) step();
      chk("relock_early", bus.locked_o, 0);
      step();
      chk("relock", bus.locked_o, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
